uart_rx: RTL

UART receive engine for 8N1 asynchronous serial links at a fixed bit period of `Freq_divider` clocks. It sits between the board RxD pin and the byte-consuming logic, and is the receive-side counterpart of the team's UART transmitter. It synchronises the line and detects the start bit. It samples each bit at mid-period with 3-sample majority voting, then emits one received byte per frame with validity and frame-error strobes.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 117 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    // 48 MHz system clock at 115200 bps; the transmitter uses the same value
    localparam int UART_DEFAULT_DIV = 416;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received byte and strobes out
interface uart_rx_if;
    import uart_pkg::*;

    logic                   iEn;
    logic                   iRxD;
    logic [UART_DATA_W-1:0] oData;
    logic                   oValid;
    logic                   oFrameErr;
    logic                   oBusy;

    modport master (
        output iEn, iRxD,
        input  oData, oValid, oFrameErr, oBusy
    );

    modport slave (
        input  iEn, iRxD,
        output oData, oValid, oFrameErr, oBusy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - RxD synchroniser, 3-sample majority vote, falling-edge detect
module uart_rx_sync (
    input  logic iClk,
    input  logic iRst_N,
    input  logic iRxD,
    output logic vote,
    output logic fall
);

    logic       s1_q;
    logic       s2_q;
    logic [2:0] hist_q;

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            hist_q <= 3'b111;
        end else begin
            s1_q   <= iRxD;
            s2_q   <= s1_q;
            hist_q <= {hist_q[1:0], s2_q};
        end
    end

    assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    // hist_q[0] is the previous synchronised sample, so the edge is seen one cycle early
    assign fall = hist_q[0] & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receive engine with mid-bit majority sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int Freq_divider = UART_DEFAULT_DIV
) (
    input  logic     iClk,
    input  logic     iRst_N,
    uart_rx_if.slave rx
);

    localparam logic [15:0] HALF_M1 = 16'(Freq_divider / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(Freq_divider - 1);

    logic vote;
    logic fall;

    uart_rx_sync u_sync (
        .iClk   (iClk),
        .iRst_N (iRst_N),
        .iRxD   (rx.iRxD),
        .vote   (vote),
        .fall   (fall)
    );

    uart_rx_state_e         state_q;
    logic [15:0]            bit_cnt_q;
    logic [2:0]             idx_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic [UART_DATA_W-1:0] data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   busy_q;

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state_q   <= IDLE;
            bit_cnt_q <= 16'd0;
            idx_q     <= 3'd0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (!rx.iEn) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                bit_cnt_q <= 16'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fall) begin
                            state_q   <= START;
                            busy_q    <= 1'b1;
                            bit_cnt_q <= 16'd0;
                        end
                    end
                    START: begin
                        if (bit_cnt_q == HALF_M1) begin
                            bit_cnt_q <= 16'd0;
                            idx_q     <= 3'd0;
                            if (vote) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= DATA;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 16'd1;
                        end
                    end
                    DATA: begin
                        if (bit_cnt_q == FULL_M1) begin
                            bit_cnt_q      <= 16'd0;
                            shift_q[idx_q] <= vote;
                            idx_q          <= idx_q + 3'd1;
                            if (idx_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 16'd1;
                        end
                    end
                    STOP: begin
                        // Leave at stop-bit mid-point so a following start edge is caught
                        if (bit_cnt_q == FULL_M1) begin
                            bit_cnt_q <= 16'd0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            if (vote) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ferr_q  <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx.oData     = data_q;
    assign rx.oValid    = valid_q;
    assign rx.oFrameErr = ferr_q;
    assign rx.oBusy     = busy_q;

endmodule
